// File: rtl/vdp_port_ctrl.sv
// ---------------------------------------------------------------------------
// vdp_port_ctrl
// TMS9918-compatible CPU port controller for the MSX video subsystem.
// Decodes CPU accesses to the data port (0x98) and the control port (0x99).
// Sequences VRAM reads, writes and read-ahead through a 14-bit
// auto-incrementing pointer. Holds R0-R7 and the status register, and
// drives the mode / table-address / colour / interrupt signals used by the
// video generator.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   io_sel            0 = data port, 1 = control port
//   io_wr, io_rd      one-cycle CPU strobes (never together, >= 3 cycles apart)
//   cpu_din/cpu_dout  CPU write data / registered CPU read data
//   vram_*            VRAM access: address, write data, one-cycle wr/rd
//                     pulses, read data sampled while the read pulse is high
//   vblank, spr_coll, spr_5th, spr_5th_num
//                     status flag sources from the video generator
//   mode .. n_int     decoded register fields for the video generator
// ---------------------------------------------------------------------------
module vdp_port_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_sel,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_wr,
    output logic        vram_rd,
    input  logic [7:0]  vram_rdata,
    input  logic        vblank,
    input  logic        spr_coll,
    input  logic        spr_5th,
    input  logic [4:0]  spr_5th_num,
    output logic [1:0]  mode,
    output logic        video_on,
    output logic [13:0] font_addr,
    output logic [13:0] name_table_addr,
    output logic [13:0] color_table_addr,
    output logic [13:0] sprite_attr_addr,
    output logic [13:0] sprite_pattern_table_addr,
    output logic [3:0]  text_color,
    output logic [3:0]  back_color,
    output logic        sprite_large,
    output logic        sprite_enlarged,
    output logic        n_int
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RDWAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0][7:0] regs_q, regs_d;
    logic [13:0]     ptr_q, ptr_d;
    logic [7:0]      lat_q, lat_d;
    logic            second_q, second_d;
    logic [7:0]      rbuf_q, rbuf_d;
    logic [7:0]      dout_q, dout_d;
    logic [13:0]     vaddr_q, vaddr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic            f_q, f_d;
    logic            c_q, c_d;
    logic            s5_q, s5_d;
    logic [4:0]      num_q, num_d;

    logic            stat_clr;
    logic [13:0]     setup_addr;

    assign setup_addr = {cpu_din[5:0], lat_q};

    // ------------------------------------------------------------------
    // Next-state / access sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        ptr_d    = ptr_q;
        lat_d    = lat_q;
        second_d = second_q;
        rbuf_d   = rbuf_q;
        dout_d   = dout_q;
        vaddr_d  = vaddr_q;
        wdata_d  = wdata_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        stat_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (io_wr) begin
                    if (io_sel) begin
                        if (!second_q) begin
                            lat_d    = cpu_din;
                            second_d = 1'b1;
                        end else begin
                            second_d = 1'b0;
                            if (cpu_din[7]) begin
                                regs_d[cpu_din[2:0]] = lat_q;
                            end else if (cpu_din[6]) begin
                                ptr_d = setup_addr;
                            end else begin
                                // Read setup: the prefetch consumes the new
                                // address, so the pointer lands one past it.
                                vaddr_d = setup_addr;
                                ptr_d   = setup_addr + 14'd1;
                                rd_d    = 1'b1;
                                state_d = ST_RDWAIT;
                            end
                        end
                    end else begin
                        // Written byte also becomes the read-ahead value.
                        vaddr_d  = ptr_q;
                        wdata_d  = cpu_din;
                        wr_d     = 1'b1;
                        rbuf_d   = cpu_din;
                        ptr_d    = ptr_q + 14'd1;
                        second_d = 1'b0;
                    end
                end else if (io_rd) begin
                    second_d = 1'b0;
                    if (io_sel) begin
                        dout_d   = {f_q, s5_q, c_q, num_q};
                        stat_clr = 1'b1;
                    end else begin
                        dout_d  = rbuf_q;
                        vaddr_d = ptr_q;
                        ptr_d   = ptr_q + 14'd1;
                        rd_d    = 1'b1;
                        state_d = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                rbuf_d  = vram_rdata;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Status flags: a set in the same cycle as a status read wins over
    // the read's clear; the read itself returns the pre-set value.
    // ------------------------------------------------------------------
    always_comb begin
        f_d   = (f_q & ~stat_clr) | vblank;
        c_d   = (c_q & ~stat_clr) | spr_coll;
        s5_d  = s5_q & ~stat_clr;
        num_d = num_q;
        // While 5S is clear the number tracks the generator; it freezes
        // once a fifth-sprite event has been latched.
        if (!s5_q) begin
            num_d = spr_5th_num;
            if (spr_5th) begin
                s5_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            regs_q   <= '0;
            ptr_q    <= '0;
            lat_q    <= '0;
            second_q <= 1'b0;
            rbuf_q   <= '0;
            dout_q   <= '0;
            vaddr_q  <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            f_q      <= 1'b0;
            c_q      <= 1'b0;
            s5_q     <= 1'b0;
            num_q    <= '0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            ptr_q    <= ptr_d;
            lat_q    <= lat_d;
            second_q <= second_d;
            rbuf_q   <= rbuf_d;
            dout_q   <= dout_d;
            vaddr_q  <= vaddr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            f_q      <= f_d;
            c_q      <= c_d;
            s5_q     <= s5_d;
            num_q    <= num_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_dout   = dout_q;
    assign vram_addr  = vaddr_q;
    assign vram_wdata = wdata_q;
    assign vram_wr    = wr_q;
    assign vram_rd    = rd_q;

    // M1 (R1[4]) beats M2 (R1[3]) beats M3 (R0[1]).
    always_comb begin
        if (regs_q[1][4])      mode = 2'd0;
        else if (regs_q[1][3]) mode = 2'd3;
        else if (regs_q[0][1]) mode = 2'd2;
        else                   mode = 2'd1;
    end

    assign video_on                  = regs_q[1][6];
    assign sprite_large              = regs_q[1][1];
    assign sprite_enlarged           = regs_q[1][0];
    assign name_table_addr           = {regs_q[2][3:0], 10'b0};
    assign color_table_addr          = {regs_q[3], 6'b0};
    assign font_addr                 = {regs_q[4][2:0], 11'b0};
    assign sprite_attr_addr          = {regs_q[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {regs_q[6][2:0], 11'b0};
    assign text_color                = regs_q[7][7:4];
    assign back_color                = regs_q[7][3:0];
    assign n_int                     = ~(f_q & regs_q[1][5]);

endmodule
